pattern_checker: RTL

- Downstream consumer of the 32-bit loopback FIFO read port.
- Regenerates the expected host test pattern locally and compares each FIFO output word that is flagged valid.
- Reports error count, word count, and first-error capture through wire-out endpoints.
- Lets the host validate pipe-in data integrity without reading it back.

---
 rtl/pattern_checker.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pattern_checker.sv
// Loopback FIFO pattern checker: regenerates the host test pattern, compares
// each valid FIFO word and reports word/error counts plus the first bad word.
module pattern_checker #(
    parameter int              WIDTH     = 32,
    parameter int              ERR_W     = 32,
    parameter logic [WIDTH-1:0] LFSR_SEED = 32'h00000001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reset_pattern,
    input  logic             reset_err_counter,
    input  logic [1:0]       pattern_mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic [WIDTH-1:0] expected,
    output logic [ERR_W-1:0] word_count,
    output logic [ERR_W-1:0] error_count,
    output logic             error_flag,
    output logic [ERR_W-1:0] first_err_index,
    output logic [WIDTH-1:0] first_err_data
);

    typedef enum logic [1:0] {
        MODE_COUNTER = 2'd0,
        MODE_WALK    = 2'd1,
        MODE_LFSR    = 2'd2,
        MODE_ALT     = 2'd3
    } pattern_mode_e;

    localparam logic [WIDTH-1:0] WALK_INIT = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALT_INIT  = {(WIDTH/2){2'b10}};
    localparam logic [ERR_W-1:0] CNT_MAX   = '1;

    function automatic logic [WIDTH-1:0] gen_init(input pattern_mode_e m);
        logic [WIDTH-1:0] v;
        case (m)
            MODE_COUNTER: v = '0;
            MODE_WALK:    v = WALK_INIT;
            MODE_LFSR:    v = LFSR_SEED;
            default:      v = ALT_INIT;
        endcase
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] gen_next(input pattern_mode_e m,
                                                  input logic [WIDTH-1:0] cur);
        logic [WIDTH-1:0] v;
        case (m)
            MODE_COUNTER: v = cur + WIDTH'(1);
            MODE_WALK:    v = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_LFSR:    v = {cur[WIDTH-2:0], cur[WIDTH-1] ^ cur[21] ^ cur[1] ^ cur[0]};
            default:      v = ~cur;
        endcase
        return v;
    endfunction

    pattern_mode_e    mode_q, mode_d;
    logic [WIDTH-1:0] gen_q, gen_d;
    logic [ERR_W-1:0] word_count_q, word_count_d;
    logic             mismatch_q, mismatch_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [ERR_W-1:0] idx_q, idx_d;
    logic [ERR_W-1:0] error_count_q, error_count_d;
    logic             error_flag_q, error_flag_d;
    logic [ERR_W-1:0] first_err_index_q, first_err_index_d;
    logic [WIDTH-1:0] first_err_data_q, first_err_data_d;

    // Handshake: data_valid alone qualifies data_in; there is no ready, so a
    // word is consumed on every edge where data_valid=1 and reset_pattern=0.
    always_comb begin
        mode_d            = mode_q;
        gen_d             = gen_q;
        word_count_d      = word_count_q;
        mismatch_d        = 1'b0;
        data_d            = data_q;
        idx_d             = idx_q;
        error_count_d     = error_count_q;
        error_flag_d      = error_flag_q;
        first_err_index_d = first_err_index_q;
        first_err_data_d  = first_err_data_q;

        // Stage 1: compare and advance; a reload discards any coincident word.
        if (reset_pattern) begin
            mode_d       = pattern_mode_e'(pattern_mode);
            gen_d        = gen_init(pattern_mode_e'(pattern_mode));
            word_count_d = '0;
        end else if (data_valid) begin
            mismatch_d = (data_in != gen_q);
            data_d     = data_in;
            idx_d      = word_count_q;
            gen_d      = gen_next(mode_q, gen_q);
            if (word_count_q != CNT_MAX) begin
                word_count_d = word_count_q + ERR_W'(1);
            end
        end

        // Stage 2: error bookkeeping; a clear drops the pending mismatch.
        if (reset_err_counter) begin
            error_count_d     = '0;
            error_flag_d      = 1'b0;
            first_err_index_d = '0;
            first_err_data_d  = '0;
        end else if (mismatch_q) begin
            error_flag_d = 1'b1;
            if (error_count_q != CNT_MAX) begin
                error_count_d = error_count_q + ERR_W'(1);
            end
            if (!error_flag_q) begin
                first_err_index_d = idx_q;
                first_err_data_d  = data_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q            <= MODE_COUNTER;
            gen_q             <= '0;
            word_count_q      <= '0;
            mismatch_q        <= 1'b0;
            data_q            <= '0;
            idx_q             <= '0;
            error_count_q     <= '0;
            error_flag_q      <= 1'b0;
            first_err_index_q <= '0;
            first_err_data_q  <= '0;
        end else begin
            mode_q            <= mode_d;
            gen_q             <= gen_d;
            word_count_q      <= word_count_d;
            mismatch_q        <= mismatch_d;
            data_q            <= data_d;
            idx_q             <= idx_d;
            error_count_q     <= error_count_d;
            error_flag_q      <= error_flag_d;
            first_err_index_q <= first_err_index_d;
            first_err_data_q  <= first_err_data_d;
        end
    end

    assign expected        = gen_q;
    assign word_count      = word_count_q;
    assign error_count     = error_count_q;
    assign error_flag      = error_flag_q;
    assign first_err_index = first_err_index_q;
    assign first_err_data  = first_err_data_q;

endmodule
